// File: rtl/counter_days.sv
// Purpose : day-of-month BCD counter (01..N) driven by the hours-counter day carry, with BCD load and 7-seg outputs.
// Latency : day digits update one clk after a tick/load edge; cm is combinational in the cd_in cycle; seg_* follow day_* combinationally.
// Backpres: none; a load in the same cycle as cd_in takes precedence and the tick is dropped (no advance, no cm).
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset (highest priority)
//   cd_in                   day tick from the hours counter
//   month[3:0], year[6:0]   current month (1..12, others = 31 days) and year in century (0..99)
//   set_en, set_ten, set_unit  BCD load request and value
//   day_ten, day_unit       BCD day
//   cm                      month carry to the months counter
//   set_err                 one-cycle pulse after a rejected load
//   seg_ten, seg_unit       7-segment patterns of the day digits
//
// Optional feature macro: LEAP_YEAR_EN (February has 29 days when year%4==0; year 00 is leap).

module Led7thanh (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // Active-low segments ordered {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module counter_days #(
    parameter int RESET_DAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cd_in,
    input  logic [3:0] month,
    input  logic [6:0] year,
    input  logic       set_en,
    input  logic [3:0] set_unit,
    input  logic [3:0] set_ten,
    output logic [3:0] day_unit,
    output logic [3:0] day_ten,
    output logic       cm,
    output logic       set_err,
    output logic [6:0] seg_unit,
    output logic [6:0] seg_ten
);
    localparam logic [3:0] RST_TEN  = 4'(RESET_DAY / 10);
    localparam logic [3:0] RST_UNIT = 4'(RESET_DAY % 10);

    logic [3:0] day_ten_q, day_ten_d;
    logic [3:0] day_unit_q, day_unit_d;
    logic       set_err_q, set_err_d;

    logic       leap;
    logic [4:0] month_len;
    logic [7:0] day_val;
    logic [7:0] set_val;
    logic       last;
    logic       set_ok;
    logic       unused_year;

`ifdef LEAP_YEAR_EN
    // year is binary 0..99, so year%4 is just the two low bits; 00 counts as leap (2000).
    assign leap = (year[1:0] == 2'b00);
`else
    assign leap = 1'b0;
`endif
    assign unused_year = ^year;

    always_comb begin
        month_len = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = leap ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    end

    assign day_val = ({4'd0, day_ten_q} * 8'd10) + {4'd0, day_unit_q};
    assign set_val = ({4'd0, set_ten} * 8'd10) + {4'd0, set_unit};

    // >= rather than == so a day left over-range by a month change still wraps on the next tick.
    assign last = (day_val >= {3'd0, month_len});

    assign set_ok = (set_unit <= 4'd9) && (set_ten <= 4'd3) &&
                    (set_val != 8'd0) && (set_val <= {3'd0, month_len});

    always_comb begin
        day_ten_d  = day_ten_q;
        day_unit_d = day_unit_q;
        set_err_d  = 1'b0;
        if (set_en) begin
            if (set_ok) begin
                day_ten_d  = set_ten;
                day_unit_d = set_unit;
            end else begin
                set_err_d  = 1'b1;
            end
        end else if (cd_in) begin
            if (last) begin
                day_ten_d  = 4'd0;
                day_unit_d = 4'd1;
            end else if (day_unit_q == 4'd9) begin
                day_ten_d  = day_ten_q + 4'd1;
                day_unit_d = 4'd0;
            end else begin
                day_unit_d = day_unit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            day_ten_q  <= RST_TEN;
            day_unit_q <= RST_UNIT;
            set_err_q  <= 1'b0;
        end else begin
            day_ten_q  <= day_ten_d;
            day_unit_q <= day_unit_d;
            set_err_q  <= set_err_d;
        end
    end

    assign cm       = cd_in & last & ~set_en & ~reset;
    assign day_ten  = day_ten_q;
    assign day_unit = day_unit_q;
    assign set_err  = set_err_q;

    Led7thanh u_seg_unit (
        .bcd (day_unit_q),
        .seg (seg_unit)
    );

    Led7thanh u_seg_ten (
        .bcd (day_ten_q),
        .seg (seg_ten)
    );
endmodule

// File: tb/tb_counter_days.sv
module tb_counter_days;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cd_in = 1'b0;
    logic [3:0] month = 4'd1;
    logic [6:0] year = 7'd0;
    logic       set_en = 1'b0;
    logic [3:0] set_unit = 4'd0;
    logic [3:0] set_ten = 4'd0;
    logic [3:0] day_unit, day_ten;
    logic       cm, set_err;
    logic [6:0] seg_unit, seg_ten;

    counter_days #(.RESET_DAY(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .cd_in    (cd_in),
        .month    (month),
        .year     (year),
        .set_en   (set_en),
        .set_unit (set_unit),
        .set_ten  (set_ten),
        .day_unit (day_unit),
        .day_ten  (day_ten),
        .cm       (cm),
        .set_err  (set_err),
        .seg_unit (seg_unit),
        .seg_ten  (seg_ten)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    localparam int K_CM = 0, K_DAY = 1, K_ERR = 2, K_SEG = 3;

    typedef struct {
        int    tag;
        int    kind;
        int    exp;
        string nm;
    } chk_t;

    chk_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        return (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    function automatic void push(input int tag, input int kind, input int exp, input string nm);
        chk_t e;
        e.tag = tag; e.kind = kind; e.exp = exp; e.nm = nm;
        q.push_back(e);
    endfunction

    // Monitor: pops every expectation due in this cycle and compares mid-cycle.
    chk_t m_e;
    int   m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            m_e = q.pop_front();
            case (m_e.kind)
                K_CM:    m_act = int'(cm);
                K_DAY:   m_act = int'({day_ten, day_unit});
                K_ERR:   m_act = int'(set_err);
                default: m_act = int'({seg_ten, seg_unit});
            endcase
            n_chk++;
            if (m_e.tag != cyc || m_act != m_e.exp)
                $display("FAIL %s: got %0h (cycle %0d) expected %0h (cycle %0d)",
                         m_e.nm, m_act, cyc, m_e.exp, m_e.tag);
            else
                n_pass++;
        end
    end

    // One cycle of stimulus: cm is expected in the drive cycle, state after the next edge.
    task automatic step(input string nm, input logic r, input logic cd, input logic se,
                        input logic [3:0] st, input logic [3:0] su, input int m, input int y,
                        input logic e_cm, input logic [3:0] e_t, input logic [3:0] e_u,
                        input logic e_err, input logic chk_seg);
        @(posedge clk);
        #1;
        reset = r; cd_in = cd; set_en = se; set_ten = st; set_unit = su;
        month = 4'(m); year = 7'(y);
        push(cyc,     K_CM,  int'(e_cm),       {nm, " cm"});
        push(cyc + 1, K_DAY, int'({e_t, e_u}), {nm, " day"});
        push(cyc + 1, K_ERR, int'(e_err),      {nm, " set_err"});
        if (chk_seg)
            push(cyc + 1, K_SEG, int'({seg_pat(e_t), seg_pat(e_u)}), {nm, " seg"});
    endtask

    initial begin
        //    name            r  cd se ten   unit  m   y   cm ten unit err seg
        step("reset",         1, 0, 0, 4'd0, 4'd0, 1,  0,  0, 0, 1,   0,  1);
        step("m4 ld29",       0, 0, 1, 4'd2, 4'd9, 4,  0,  0, 2, 9,   0,  1);
        step("m4 tick30",     0, 1, 0, 4'd0, 4'd0, 4,  0,  0, 3, 0,   0,  0);
        step("m4 wrap",       0, 1, 0, 4'd0, 4'd0, 4,  0,  1, 0, 1,   0,  0);
        step("m1 ld31",       0, 0, 1, 4'd3, 4'd1, 1,  0,  0, 3, 1,   0,  0);
        step("m1 wrap",       0, 1, 0, 4'd0, 4'd0, 1,  0,  1, 0, 1,   0,  0);
        step("m2y23 ld28",    0, 0, 1, 4'd2, 4'd8, 2,  23, 0, 2, 8,   0,  0);
        step("m2y23 wrap",    0, 1, 0, 4'd0, 4'd0, 2,  23, 1, 0, 1,   0,  0);
        step("m2y24 ld28",    0, 0, 1, 4'd2, 4'd8, 2,  24, 0, 2, 8,   0,  0);
`ifdef LEAP_YEAR_EN
        step("leap tick29",   0, 1, 0, 4'd0, 4'd0, 2,  24, 0, 2, 9,   0,  1);
        step("leap wrap",     0, 1, 0, 4'd0, 4'd0, 2,  24, 1, 0, 1,   0,  0);
        step("y00 ld29",      0, 0, 1, 4'd2, 4'd9, 2,  0,  0, 2, 9,   0,  0);
        step("y00 wrap",      0, 1, 0, 4'd0, 4'd0, 2,  0,  1, 0, 1,   0,  0);
`else
        step("noleap wrap",   0, 1, 0, 4'd0, 4'd0, 2,  24, 1, 0, 1,   0,  0);
        step("noleap ld29",   0, 0, 1, 4'd2, 4'd9, 2,  24, 0, 0, 1,   1,  0);
`endif
        step("m6 ld31 rej",   0, 0, 1, 4'd3, 4'd1, 6,  0,  0, 0, 1,   1,  0);
        step("err clears",    0, 0, 0, 4'd0, 4'd0, 6,  0,  0, 0, 1,   0,  0);
        step("ld3A rej",      0, 0, 1, 4'd3, 4'hA, 6,  0,  0, 0, 1,   1,  0);
        step("ld15",          0, 0, 1, 4'd1, 4'd5, 6,  0,  0, 1, 5,   0,  1);
        step("ld00 rej",      0, 0, 1, 4'd0, 4'd0, 6,  0,  0, 1, 5,   1,  0);
        step("ld09",          0, 0, 1, 4'd0, 4'd9, 6,  0,  0, 0, 9,   0,  0);
        step("tick 09->10",   0, 1, 0, 4'd0, 4'd0, 6,  0,  0, 1, 0,   0,  1);
        step("m1 ld31 b",     0, 0, 1, 4'd3, 4'd1, 1,  0,  0, 3, 1,   0,  0);
        step("m9 hold",       0, 0, 0, 4'd0, 4'd0, 9,  0,  0, 3, 1,   0,  0);
        step("m9 overrange",  0, 1, 0, 4'd0, 4'd0, 9,  0,  1, 0, 1,   0,  0);
        step("m13 ld31",      0, 0, 1, 4'd3, 4'd1, 13, 0,  0, 3, 1,   0,  0);
        step("m0 wrap31",     0, 1, 0, 4'd0, 4'd0, 0,  0,  1, 0, 1,   0,  0);
        step("ld10 with cd",  0, 1, 1, 4'd1, 4'd0, 1,  0,  0, 1, 0,   0,  0);
        step("tick 11",       0, 1, 0, 4'd0, 4'd0, 1,  0,  0, 1, 1,   0,  0);
        step("rst cd se",     1, 1, 1, 4'd2, 4'd0, 1,  0,  0, 0, 1,   0,  1);
        step("idle",          0, 0, 0, 4'd0, 4'd0, 1,  0,  0, 0, 1,   0,  0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d checks still pending, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
